seq_cla_subtractor: RTL and testbench

SEQ_CLA_SUBTRACTOR -- requirements
Module: seq_cla_subtractor

---
 rtl/arith_pkg.sv | 5 +
 rtl/cla4_slice.sv | 30 +++
 rtl/seq_cla_subtractor.sv | 89 ++++++++
 tb/tb_seq_cla_subtractor.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state type and nibble width for the sequential arithmetic blocks
package arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: 4-bit generate/propagate carry-lookahead adder slice; c3 port exists only with SUB_OVERFLOW_EN
module cla4_slice
  import arith_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic                c3
`endif
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ c[3:0];
  assign cout = c[4];
`ifdef SUB_OVERFLOW_EN
  assign c3 = c[3];
`endif
endmodule

// File: rtl/seq_cla_subtractor.sv
// seq_cla_subtractor: nibble-serial a - b - bin through one CLA slice, valid/ready handshake.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module seq_cla_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int NN = WIDTH / NIBBLE_W;
  localparam int IW = $clog2(NN);
  state_t state, next;
  logic [WIDTH-1:0] a_r, nb_r;
  logic [IW-1:0] idx;
  logic [NIBBLE_W-1:0] s;
  logic carry, co, last, acc;
  assign acc       = in_valid && in_ready;
  assign last      = idx == IW'(NN - 1);
  assign out_valid = state == DONE;
`ifdef SUB_OVERFLOW_EN
  logic c3;
`endif
  cla4_slice u_slice (
    .a   (a_r[idx*NIBBLE_W +: NIBBLE_W]),
    .b   (nb_r[idx*NIBBLE_W +: NIBBLE_W]),
    .cin (carry),
    .sum (s),
    .cout(co)
`ifdef SUB_OVERFLOW_EN
    ,
    .c3  (c3)
`endif
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= next;
  always_comb begin
    next = state;
    next = (state == IDLE && acc)       ? RUN  :
           (state == RUN && last)       ? DONE :
           (state == DONE && out_ready) ? IDLE : state;
  end
  // in_ready is registered so it stays low until the first edge after reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      in_ready <= 1'b0;
      a_r      <= '0;
      nb_r     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      diff     <= '0;
      bout     <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf      <= 1'b0;
`endif
    end else begin
      in_ready <= next == IDLE;
      if (state == IDLE && acc) begin
        a_r   <= a;
        nb_r  <= ~b;
        carry <= ~bin;
        idx   <= '0;
      end else if (state == RUN) begin
        diff[idx*NIBBLE_W +: NIBBLE_W] <= s;
        carry <= co;
        idx   <= idx + IW'(1);
        if (last) begin
          bout <= ~co;
`ifdef SUB_OVERFLOW_EN
          ovf  <= c3 ^ co;
`endif
        end
      end
    end
endmodule

// File: tb/tb_seq_cla_subtractor.sv
// tb_seq_cla_subtractor: random + directed checks of seq_cla_subtractor against a transaction-level model
module tb_seq_cla_subtractor;
  localparam int W  = 16;
  localparam int NN = W / 4;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, bout;
  logic [W-1:0] diff;
`ifdef SUB_OVERFLOW_EN
  logic ovf;
`endif
  int checks = 0, failures = 0;

  seq_cla_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef SUB_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction model: accept when ready, result NN edges later, hold until out_ready
  logic m_ready = 1'b0, m_valid = 1'b0, m_pend = 1'b0;
  int m_lat = 0;
  logic [W-1:0] e_diff = '0;
  logic e_bout = 1'b0, e_ovf = 1'b0;
  always @(posedge clk or posedge rst) begin
    int sa, sb, sd;
    if (rst) begin
      m_ready = 1'b0; m_valid = 1'b0; m_pend = 1'b0;
    end else if (m_valid) begin
      if (out_ready) begin m_valid = 1'b0; m_ready = 1'b1; end
    end else if (m_pend) begin
      m_lat++;
      if (m_lat == NN) begin m_pend = 1'b0; m_valid = 1'b1; end
    end else if (!m_ready) begin
      m_ready = 1'b1;
    end else if (in_valid) begin
      m_ready = 1'b0; m_pend = 1'b1; m_lat = 0;
      e_diff = a - b - W'(bin);
      e_bout = {1'b0, a} < ({1'b0, b} + 17'(bin));
      sa = $signed(a); sb = $signed(b);
      sd = sa - sb - int'(bin);
      e_ovf = (sd > 32767) || (sd < -32768);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout, 0);
`ifdef SUB_OVERFLOW_EN
      chk("rst_ovf", ovf, 0);
`endif
    end else begin
      chk("in_ready", in_ready, m_ready);
      chk("out_valid", out_valid, m_valid);
      chk("excl", in_ready & out_valid, 0);
      if (m_valid) begin
        chk("diff", diff, e_diff);
        chk("bout", bout, e_bout);
`ifdef SUB_OVERFLOW_EN
        chk("ovf", ovf, e_ovf);
`endif
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
    chk("ready_timeout", in_ready, 1);
  endtask

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic tbin,
                    input int hold, input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    wait_ready();
    a = ta; b = tb_b; bin = tbin; in_valid = 1'b1;
    @(negedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); #1; n++; end
    chk("latency", n, NN);
    chk("lit_diff", diff, ed);
    chk("lit_bout", bout, eb);
`ifdef SUB_OVERFLOW_EN
    chk("lit_ovf", ovf, eo);
`endif
    chk("model_diff", e_diff, ed);
    chk("model_bout", e_bout, eb);
    chk("model_ovf", e_ovf, eo);
    repeat (hold) begin @(negedge clk); #1; end
    out_ready = 1'b1;
    @(negedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    op(16'h1234, 16'h0234, 1'b0, 0, 16'h1000, 1'b0, 1'b0);
    op(16'h0000, 16'h0001, 1'b0, 10, 16'hFFFF, 1'b1, 1'b0);
    op(16'h0005, 16'h0003, 1'b1, 0, 16'h0001, 1'b0, 1'b0);
    op(16'h8000, 16'h0001, 1'b0, 3, 16'h7FFF, 1'b0, 1'b1);
    // reset pulsed during the second RUN cycle
    wait_ready();
    a = 16'h5A5A; b = 16'h0101; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_bout", bout, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    op(16'hFFFF, 16'hFFFF, 1'b0, 0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      in_valid  = 1'($urandom);
      out_ready = ($urandom % 3) != 0;
      a   = ($urandom % 5 == 0) ? (($urandom % 2 == 0) ? 16'h0000 : 16'hFFFF) : W'($urandom);
      b   = ($urandom % 5 == 0) ? (($urandom % 2 == 0) ? 16'h8000 : 16'h7FFF) : W'($urandom);
      bin = 1'($urandom);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
